serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 151 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first, one bit per clock.
// Optional feature: define SERIAL_ADDER_OVERFLOW_EN to add the overflow_out port.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             carry_out,
  output logic             overflow_out
`else
  output logic             carry_out
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  state_t           state_r, next_state_s;
  logic             load_s, shift_s, finish_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r, b_sh_r;
  // Only WIDTH-1 bits are stored; the final bit comes straight from the cell.
  logic [WIDTH-2:0] sum_sh_r;
  logic             carry_r;
  logic [1:0]       cell_s;
  logic [WIDTH-1:0] sum_next_s;
  logic             busy_r, done_r, carry_out_r;
  logic [WIDTH-1:0] sum_r;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_r;
`endif

  assign cell_s     = full_add(a_sh_r[0], b_sh_r[0], carry_r);
  assign sum_next_s = {cell_s[0], sum_sh_r};

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_in) begin
          next_state_s = SHIFT;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == LAST_BIT) begin
          next_state_s = DONE;
          finish_s     = 1'b1;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand shift registers, running carry and bit counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
    end else if (load_s) begin
      a_sh_r  <= a_in;
      b_sh_r  <= b_in;
      carry_r <= c_in;
      cnt_r   <= '0;
    end else if (shift_s) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      sum_sh_r <= sum_next_s[WIDTH-1:1];
      carry_r  <= cell_s[1];
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end

  // Result registers: written only on the SHIFT->DONE transition
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sum_r       <= '0;
      carry_out_r <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_r       <= 1'b0;
`endif
    end else if (finish_s) begin
      sum_r       <= sum_next_s;
      carry_out_r <= cell_s[1];
`ifdef SERIAL_ADDER_OVERFLOW_EN
      // carry_r still holds the carry into the MSB on the last shift cycle
      ovf_r       <= carry_r ^ cell_s[1];
`endif
    end
  end

  // Registered status flags that track the upcoming state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == SHIFT);
      done_r <= (next_state_s == DONE);
    end
  end

  assign busy_out  = busy_r;
  assign done_out  = done_r;
  assign sum_out   = sum_r;
  assign carry_out = carry_out_r;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow_out = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: 8-bit and 32-bit instances, directed cases then random traffic.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [32:0] res;
    logic        ovf;
    longint      due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b0;
  longint cyc = 0;

  logic        start8 = 1'b0, c8 = 1'b0, busy8, done8, carry8;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0, sum8;
  logic        start32 = 1'b0, c32 = 1'b0, busy32, done32, carry32;
  logic [31:0] a32 = 32'd0, b32 = 32'd0, sum32;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic        ovf8, ovf32;
`endif

  exp_t q8[$];
  exp_t q32[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [8:0]  prev8;
  logic [32:0] prev32;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_in(rst), .start_in(start8), .a_in(a8), .b_in(b8), .c_in(c8),
    .busy_out(busy8), .done_out(done8), .sum_out(sum8),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .carry_out(carry8), .overflow_out(ovf8)
`else
    .carry_out(carry8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk_in(clk), .rst_in(rst), .start_in(start32), .a_in(a32), .b_in(b32), .c_in(c32),
    .busy_out(busy32), .done_out(done32), .sum_out(sum32),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .carry_out(carry32), .overflow_out(ovf32)
`else
    .carry_out(carry32)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain integer sum, and signed range test for overflow.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input longint due);
    exp_t   e;
    longint mask, ua, ub, sa, sb, full, sres, half;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    full = ua + ub + longint'(c);
    sa   = (ua >= half) ? ua - (half * 2) : ua;
    sb   = (ub >= half) ? ub - (half * 2) : ub;
    sres = sa + sb + longint'(c);
    e.res = full[32:0];
    e.ovf = (sres > half - 1) || (sres < -half);
    e.due = due;
    return e;
  endfunction

  task automatic drive(input int d, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    if (d == 0) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; c8 = c;
    end else begin
      start32 = st; a32 = a; b32 = b; c32 = c;
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns when the next start may be issued.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input bit noise);
    int   w;
    exp_t e;
    w = (d == 0) ? 8 : 32;
    e = model(w, a, b, c, cyc + 1 + longint'(w));
    drive(d, 1'b1, a, b, c);
    if (d == 0) q8.push_back(e);
    else q32.push_back(e);
    repeat (w + 1) begin
      @(posedge clk); #1;
      drive(d, noise ? 1'($urandom_range(0, 1)) : 1'b0, $urandom(), $urandom(),
            1'($urandom_range(0, 1)));
    end
    @(posedge clk); #1;
    drive(d, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input int cycles, input logic st);
    rst = 1'b1;
    q8.delete();
    q32.delete();
    drive(0, st, 32'hFF, 32'h01, 1'b1);
    drive(1, st, 32'hFFFF_FFFF, 32'h1, 1'b1);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return 32'hFFFF_FFFF;
    else if (sel == 1) return 32'h0000_0000;
    else return $urandom();
  endfunction

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("rst_busy8", 64'(busy8), 64'd0);
      chk("rst_done8", 64'(done8), 64'd0);
      chk("rst_result8", 64'({carry8, sum8}), 64'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
      chk("rst_ovf8", 64'(ovf8), 64'd0);
`endif
    end else if (done8) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 64'(done8), 64'd0);
      end else begin
        e = q8.pop_front();
        chk("result8", 64'({carry8, sum8}), 64'(e.res));
        chk("latency8", 64'(cyc), 64'(e.due));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("ovf8", 64'(ovf8), 64'(e.ovf));
`endif
      end
    end else begin
      chk("hold8", 64'({carry8, sum8}), 64'(prev8));
    end
    prev8 = {carry8, sum8};
  end

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("rst_busy32", 64'(busy32), 64'd0);
      chk("rst_done32", 64'(done32), 64'd0);
      chk("rst_result32", 64'({carry32, sum32}), 64'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
      chk("rst_ovf32", 64'(ovf32), 64'd0);
`endif
    end else if (done32) begin
      if (q32.size() == 0) begin
        chk("done32_unexpected", 64'(done32), 64'd0);
      end else begin
        e = q32.pop_front();
        chk("result32", 64'({carry32, sum32}), 64'(e.res));
        chk("latency32", 64'(cyc), 64'(e.due));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("ovf32", 64'(ovf32), 64'(e.ovf));
`endif
      end
    end else begin
      chk("hold32", 64'({carry32, sum32}), 64'(prev32));
    end
    prev32 = {carry32, sum32};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    // Reset with start held high: reset must win.
    @(posedge clk); #1;
    do_reset(3, 1'b1);
    @(posedge clk); #1;

    run_op(0, 32'hA5, 32'h5A, 1'b1, 1'b0);
    run_op(0, 32'h7F, 32'h01, 1'b0, 1'b0);
    run_op(0, 32'h3C, 32'hC3, 1'b0, 1'b1);
    run_op(0, 32'h80, 32'h80, 1'b1, 1'b1);

    // Abort mid-operation: reset sampled on the fourth SHIFT edge.
    drive(0, 1'b1, 32'h12, 32'h34, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      drive(0, 1'b0, $urandom(), $urandom(), 1'b1);
    end
    chk("abort_busy_before", 64'(busy8), 64'd1);
    do_reset(1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_busy_after", 64'(busy8), 64'd0);
    run_op(0, 32'h55, 32'h66, 1'b1, 1'b0);

    // Back-to-back operations
    run_op(0, 32'hFF, 32'h01, 1'b0, 1'b0);
    run_op(0, 32'h00, 32'h00, 1'b1, 1'b0);

    for (int i = 0; i < 700; i++) begin
      run_op(0, pick(), pick(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 400; i++) begin
      run_op(1, pick(), pick(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    guard = 0;
    while ((q8.size() + q32.size()) != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("pending_results", 64'(q8.size() + q32.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
